memory_master: RTL and testbench
================================

Name: memory_master

Overview:
- Bus initiator between the CPU load/store path and the word-wide memory/peripheral bus.
- Accepts byte, halfword and word load/store requests at byte addresses.
- Drives the word address, byte strobes, lane-steered write data and read/write strobes.
- Extracts, shifts and sign/zero-extends read data, then returns one response per request.

Parameters:
- WAIT_STATES, 0, extra cycles the bus strobes are held beyond the minimum single access cycle (0..15).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready at a rising edge.
- req_write  input  1  1 = store, 0 = load.
- req_width  input  2  access width, encoding from the package.
- req_signed  input  1  sign-extend loads (ignored for word and stores).
- req_address  input  32  byte address.
- req_data  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle response pulse.
- resp_data  output  32  load result, extended; 0 for stores and errors.
- resp_error  output  1  valid with resp_valid; misaligned or reserved width.
- bus_address  output  30  word address, bits 31:2.
- bus_data_out  output  32  lane-steered write data.
- bus_data_in  input  32  read data from the slave.
- bus_data_strobes  output  4  byte lane enables; [3] = bits 31:24.
- bus_read  output  1  read strobe.
- bus_write  output  1  write strobe.

Behaviour:
- Byte lanes are big-endian: offset 0 maps to lane 3 (31:24), offset 3 to lane 0 (7:0).
- Halfword offset 0 uses bits 31:16 (strobes 1100); offset 2 uses bits 15:0 (strobes 0011).
- Store data is replicated across lanes: byte to all four, halfword to both halves.
- States are IDLE and ACCESS.
- Reset (asynchronous): state = IDLE, wait counter = 0, all bus outputs 0, resp_valid = 0, resp_data = 0, resp_error = 0. req_ready is 1 whenever the state is IDLE, including during reset.
- IDLE, accepting an aligned request:
  - At the accepting edge, register bus_address, bus_data_strobes and bus_data_out.
  - Assert bus_read or bus_write.
  - Load the wait counter with WAIT_STATES; go to ACCESS.
- ACCESS: all bus outputs are held stable. The slave samples on the falling edge, so bus_data_in is valid at the next rising edge.
  - Counter nonzero: decrement it.
  - Counter zero, at that edge:
    - Capture and steer bus_data_in (loads) or force resp_data = 0 (stores).
    - Pulse resp_valid.
    - Clear bus_read, bus_write and bus_data_strobes; go to IDLE.
- Latency: response in the cycle after WAIT_STATES+1 access cycles.
- A new request may be accepted in the same cycle resp_valid is high. Peak rate is one access per two cycles at WAIT_STATES=0.
- Bus_address and bus_data_out are don't-care outside ACCESS; they hold their last values.
- Load extraction:
  - Byte: the selected lane goes to 7:0.
  - Halfword: the selected half goes to 15:0.
  - Upper bits are sign-filled if req_signed, else zero-filled; req_signed is latched at accept.
- req_width 11 (reserved) is treated as an error.
- Reset asserted mid-ACCESS: strobes drop immediately and the response is lost; IDLE follows reset release.

Optional Feature:
- MEMORY_MASTER_ALIGN_CHECK_EN defined:
  - Misaligned halfword (odd address) or word (address[1:0] != 0) runs no bus cycle, as does reserved width.
  - resp_valid = 1, resp_error = 1 and resp_data = 0 at the next edge; state stays IDLE.
- Undefined:
  - Low offset bits are masked to the access width (word forced to offset 0, halfword offset bit 0 forced to 0).
  - Reserved width is treated as word; resp_error is tied 0.

Decomposition:
- Package memory_master_pkg holds:
  - Width encodings: WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10, WIDTH_RSVD=2'b11.
  - State encodings.
  - Strobe constants STROBES_WORD=4'b1111, STROBES_HI=4'b1100, STROBES_LO=4'b0011.
- One combinational sub-module, byte_lane_steer:
  - Store side: strobe generation and data replication from width and offset.
  - Load side: lane extraction and extension.
- memory_master keeps the FSM, wait counter and registers.

Test Plan:
- Slave holds 0x8899AABB at byte address 0x10. Word load 0x10 -> bus_address=0x4, strobes 1111, bus_read high exactly 1 cycle; resp_data=0x8899AABB, resp_error=0 one cycle later.
- Byte load 0x11, signed -> 0xFFFFFF99; same load unsigned -> 0x00000099; byte load 0x13, signed -> 0xFFFFFFBB.
- Halfword store 0x12, data 0x00001234 -> strobes 0011, bus_data_out=0x12341234, bus_write 1 cycle, resp_data=0; a following word load of 0x10, accepted in the resp_valid cycle, returns 0x88991234.
- Word load 0x13 with the macro defined -> no bus_read, resp_error=1, resp_data=0 after 1 cycle; without the macro -> reads 0x10 and returns 0x8899AABB, resp_error=0.
- WAIT_STATES=2: word load -> bus_read and address stable for 3 cycles, req_ready low for 3 cycles, resp_valid in the 4th cycle.
- Reset pulsed low during ACCESS of a store -> bus_write and strobes go to 0 without a clock edge, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/memory_master_pkg.sv
// rtl/memory_master_pkg.sv - width, state and strobe encodings shared by memory_master
package memory_master_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;
  localparam logic [1:0] WIDTH_RSVD = 2'b11;

  localparam logic [3:0] STROBES_WORD = 4'b1111;
  localparam logic [3:0] STROBES_HI   = 4'b1100;
  localparam logic [3:0] STROBES_LO   = 4'b0011;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/byte_lane_steer.sv
// rtl/byte_lane_steer.sv - big-endian byte lane steering for stores and load extraction/extension
module byte_lane_steer
  import memory_master_pkg::*;
(
  input  logic [1:0]  store_width,
  input  logic [1:0]  store_offset,
  input  logic [31:0] store_data,
  output logic [3:0]  store_strobes,
  output logic [31:0] store_lanes,
  input  logic [1:0]  load_width,
  input  logic [1:0]  load_offset,
  input  logic        load_signed,
  input  logic [31:0] load_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    store_strobes = STROBES_WORD;
    store_lanes   = store_data;
    case (store_width)
      WIDTH_BYTE: begin
        // offset 0 is the most significant lane
        store_strobes = 4'b1000 >> store_offset;
        store_lanes   = {4{store_data[7:0]}};
      end
      WIDTH_HALF: begin
        store_strobes = store_offset[1] ? STROBES_LO : STROBES_HI;
        store_lanes   = {2{store_data[15:0]}};
      end
      default: begin
        store_strobes = STROBES_WORD;
        store_lanes   = store_data;
      end
    endcase
  end

  always_comb begin
    sel_byte = load_lanes[31:24];
    case (load_offset)
      2'd0:    sel_byte = load_lanes[31:24];
      2'd1:    sel_byte = load_lanes[23:16];
      2'd2:    sel_byte = load_lanes[15:8];
      default: sel_byte = load_lanes[7:0];
    endcase
    sel_half = load_offset[1] ? load_lanes[15:0] : load_lanes[31:16];

    load_data = load_lanes;
    case (load_width)
      WIDTH_BYTE: load_data = {{24{load_signed & sel_byte[7]}}, sel_byte};
      WIDTH_HALF: load_data = {{16{load_signed & sel_half[15]}}, sel_half};
      default:    load_data = load_lanes;
    endcase
  end

endmodule

// File: rtl/memory_master.sv
// rtl/memory_master.sv - CPU load/store to word bus initiator; MEMORY_MASTER_ALIGN_CHECK_EN enables misalignment errors
module memory_master
  import memory_master_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [29:0] bus_address,
  output logic [31:0] bus_data_out,
  input  logic [31:0] bus_data_in,
  output logic [3:0]  bus_data_strobes,
  output logic        bus_read,
  output logic        bus_write
);

  state_t      state, state_next;
  logic [3:0]  wait_cnt;
  logic [1:0]  acc_width, acc_offset;
  logic        acc_signed, acc_write;
  logic        accept, bad_request, access_done;
  logic [1:0]  eff_width, eff_offset;
  logic [3:0]  st_strobes;
  logic [31:0] st_lanes, ld_data;

  assign req_ready   = (state == IDLE);
  assign accept      = req_valid && req_ready;
  assign access_done = (state == ACCESS) && (wait_cnt == 4'd0);

  always_comb begin
    bad_request = 1'b0;
    eff_width   = req_width;
    eff_offset  = req_address[1:0];
`ifdef MEMORY_MASTER_ALIGN_CHECK_EN
    case (req_width)
      WIDTH_HALF: bad_request = req_address[0];
      WIDTH_WORD: bad_request = |req_address[1:0];
      WIDTH_RSVD: bad_request = 1'b1;
      default:    bad_request = 1'b0;
    endcase
`else
    // misaligned offsets are silently rounded down to the access width
    case (req_width)
      WIDTH_HALF: eff_offset = {req_address[1], 1'b0};
      WIDTH_WORD, WIDTH_RSVD: begin
        eff_width  = WIDTH_WORD;
        eff_offset = 2'b00;
      end
      default: eff_offset = req_address[1:0];
    endcase
`endif
  end

  byte_lane_steer u_steer (
    .store_width   (eff_width),
    .store_offset  (eff_offset),
    .store_data    (req_data),
    .store_strobes (st_strobes),
    .store_lanes   (st_lanes),
    .load_width    (acc_width),
    .load_offset   (acc_offset),
    .load_signed   (acc_signed),
    .load_lanes    (bus_data_in),
    .load_data     (ld_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !bad_request) state_next = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt         <= 4'd0;
      acc_width        <= WIDTH_WORD;
      acc_offset       <= 2'b00;
      acc_signed       <= 1'b0;
      acc_write        <= 1'b0;
      bus_address      <= '0;
      bus_data_out     <= '0;
      bus_data_strobes <= '0;
      bus_read         <= 1'b0;
      bus_write        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      resp_error       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        if (bad_request) begin
          resp_valid <= 1'b1;
          resp_error <= 1'b1;
          resp_data  <= '0;
        end else begin
          bus_address      <= req_address[31:2];
          bus_data_strobes <= st_strobes;
          bus_data_out     <= st_lanes;
          bus_read         <= !req_write;
          bus_write        <= req_write;
          wait_cnt         <= WAIT_STATES[3:0];
          acc_width        <= eff_width;
          acc_offset       <= eff_offset;
          acc_signed       <= req_signed;
          acc_write        <= req_write;
        end
      end else if (access_done) begin
        resp_valid       <= 1'b1;
        resp_error       <= 1'b0;
        resp_data        <= acc_write ? 32'd0 : ld_data;
        bus_read         <= 1'b0;
        bus_write        <= 1'b0;
        bus_data_strobes <= 4'b0000;
      end else if (state == ACCESS) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_memory_master.sv
// tb/tb_memory_master.sv - directed self-checking bench for memory_master (WAIT_STATES 0 and 2)
module tb_memory_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_width = 2'b10;
  logic [31:0] req_address = '0, req_data = '0;
  logic        req_ready, resp_valid, resp_error, bus_read, bus_write;
  logic [31:0] resp_data, bus_data_out;
  logic [31:0] bus_data_in = '0;
  logic [29:0] bus_address;
  logic [3:0]  bus_data_strobes;

  logic        req_valid2 = 1'b0;
  logic [31:0] req_address2 = '0;
  logic        req_ready2, resp_valid2, resp_error2, bus_read2, bus_write2;
  logic [31:0] resp_data2, bus_data_out2;
  logic [31:0] bus_data_in2 = '0;
  logic [29:0] bus_address2;
  logic [3:0]  bus_data_strobes2;

  logic [31:0] mem [0:63];
  int n_assert = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  memory_master #(.WAIT_STATES(0)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_width(req_width), .req_signed(req_signed), .req_address(req_address),
    .req_data(req_data), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_error(resp_error), .bus_address(bus_address), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .bus_data_strobes(bus_data_strobes),
    .bus_read(bus_read), .bus_write(bus_write)
  );

  memory_master #(.WAIT_STATES(2)) dut_ws2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(1'b0),
    .req_width(2'b10), .req_signed(1'b0), .req_address(req_address2),
    .req_data(32'd0), .resp_valid(resp_valid2), .resp_data(resp_data2),
    .resp_error(resp_error2), .bus_address(bus_address2), .bus_data_out(bus_data_out2),
    .bus_data_in(bus_data_in2), .bus_data_strobes(bus_data_strobes2),
    .bus_read(bus_read2), .bus_write(bus_write2)
  );

  // slave samples the strobes on the falling edge
  always @(negedge clock) begin
    if (bus_read) bus_data_in <= mem[bus_address[5:0]];
    if (bus_write) begin
      for (int i = 0; i < 4; i++)
        if (bus_data_strobes[i]) mem[bus_address[5:0]][8*i +: 8] <= bus_data_out[8*i +: 8];
    end
    if (bus_read2) bus_data_in2 <= mem[bus_address2[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("assertion %s", tag);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] width, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] data);
    req_valid   = 1'b1;
    req_write   = w;
    req_width   = width;
    req_signed  = sgn;
    req_address = addr;
    req_data    = data;
  endtask

  task automatic load_check(input string tag, input logic [1:0] width, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b0, width, sgn, addr, 32'd0);
    tick;
    req_valid = 1'b0;
    check({tag, "_bus_read"}, {31'd0, bus_read}, 32'd1);
    tick;
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_resp_data"}, resp_data, exp);
    check({tag, "_resp_error"}, {31'd0, resp_error}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[4] = 32'h8899AABB;

    #2;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_bus_read", {31'd0, bus_read}, 32'd0);
    check("rst_strobes", {28'd0, bus_data_strobes}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    tick;
    reset = 1'b1;
    tick;

    // word load 0x10
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    tick;
    req_valid = 1'b0;
    check("wl_bus_address", {2'd0, bus_address}, 32'h4);
    check("wl_strobes", {28'd0, bus_data_strobes}, 32'hF);
    check("wl_bus_read", {31'd0, bus_read}, 32'd1);
    check("wl_req_ready", {31'd0, req_ready}, 32'd0);
    check("wl_resp_valid_early", {31'd0, resp_valid}, 32'd0);
    tick;
    check("wl_bus_read_drop", {31'd0, bus_read}, 32'd0);
    check("wl_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("wl_resp_data", resp_data, 32'h8899AABB);
    check("wl_resp_error", {31'd0, resp_error}, 32'd0);
    tick;
    check("wl_resp_pulse", {31'd0, resp_valid}, 32'd0);

    load_check("lb11s", 2'b00, 1'b1, 32'h11, 32'hFFFFFF99);
    load_check("lb11u", 2'b00, 1'b0, 32'h11, 32'h00000099);
    load_check("lb13s", 2'b00, 1'b1, 32'h13, 32'hFFFFFFBB);
    load_check("lb10u", 2'b00, 1'b0, 32'h10, 32'h00000088);
    load_check("lh12s", 2'b01, 1'b1, 32'h12, 32'hFFFFAABB);
    load_check("lh10u", 2'b01, 1'b0, 32'h10, 32'h00008899);

    // halfword store then back-to-back word load
    drive(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
    tick;
    req_valid = 1'b0;
    check("sh_strobes", {28'd0, bus_data_strobes}, 32'h3);
    check("sh_data_out", bus_data_out, 32'h12341234);
    check("sh_bus_write", {31'd0, bus_write}, 32'd1);
    check("sh_bus_read", {31'd0, bus_read}, 32'd0);
    tick;
    check("sh_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("sh_resp_data", resp_data, 32'd0);
    check("sh_bus_write_drop", {31'd0, bus_write}, 32'd0);
    check("sh_req_ready", {31'd0, req_ready}, 32'd1);
    load_check("b2b", 2'b10, 1'b0, 32'h10, 32'h88991234);

    // byte store to offset 2 restores lane 1
    drive(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
    tick;
    req_valid = 1'b0;
    check("sb_strobes", {28'd0, bus_data_strobes}, 32'h2);
    check("sb_data_out", bus_data_out, 32'hAAAAAAAA);
    tick;
    check("sb_resp_valid", {31'd0, resp_valid}, 32'd1);
    drive(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000BB);
    tick;
    req_valid = 1'b0;
    check("sb3_strobes", {28'd0, bus_data_strobes}, 32'h1);
    tick;
    load_check("restore", 2'b10, 1'b0, 32'h10, 32'h8899AABB);

    // misaligned word load 0x13
`ifdef MEMORY_MASTER_ALIGN_CHECK_EN
    drive(1'b0, 2'b10, 1'b0, 32'h13, 32'd0);
    tick;
    req_valid = 1'b0;
    check("mis_bus_read", {31'd0, bus_read}, 32'd0);
    check("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("mis_resp_error", {31'd0, resp_error}, 32'd1);
    check("mis_resp_data", resp_data, 32'd0);
    check("mis_req_ready", {31'd0, req_ready}, 32'd1);
    tick;
    drive(1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    tick;
    req_valid = 1'b0;
    check("rsvd_resp_error", {31'd0, resp_error}, 32'd1);
    check("rsvd_bus_read", {31'd0, bus_read}, 32'd0);
    tick;
`else
    drive(1'b0, 2'b10, 1'b0, 32'h13, 32'd0);
    tick;
    req_valid = 1'b0;
    check("mis_bus_address", {2'd0, bus_address}, 32'h4);
    check("mis_strobes", {28'd0, bus_data_strobes}, 32'hF);
    tick;
    check("mis_resp_data", resp_data, 32'h8899AABB);
    check("mis_resp_error", {31'd0, resp_error}, 32'd0);
    load_check("rsvd", 2'b11, 1'b0, 32'h12, 32'h8899AABB);
`endif

    // WAIT_STATES=2 instance
    req_valid2   = 1'b1;
    req_address2 = 32'h10;
    tick;
    req_valid2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("ws2_bus_read_c%0d", c), {31'd0, bus_read2}, 32'd1);
      check($sformatf("ws2_addr_c%0d", c), {2'd0, bus_address2}, 32'h4);
      check($sformatf("ws2_ready_c%0d", c), {31'd0, req_ready2}, 32'd0);
      check($sformatf("ws2_resp_valid_c%0d", c), {31'd0, resp_valid2}, 32'd0);
      tick;
    end
    check("ws2_resp_valid", {31'd0, resp_valid2}, 32'd1);
    check("ws2_resp_data", resp_data2, 32'h8899AABB);
    check("ws2_bus_read_drop", {31'd0, bus_read2}, 32'd0);
    check("ws2_req_ready", {31'd0, req_ready2}, 32'd1);
    tick;

    // reset in the middle of a store
    drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    tick;
    req_valid = 1'b0;
    check("rs_bus_write", {31'd0, bus_write}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rs_bus_write_drop", {31'd0, bus_write}, 32'd0);
    check("rs_strobes_drop", {28'd0, bus_data_strobes}, 32'd0);
    check("rs_req_ready", {31'd0, req_ready}, 32'd1);
    #1 reset = 1'b1;
    tick;
    check("rs_no_resp", {31'd0, resp_valid}, 32'd0);
    check("rs_ready_after", {31'd0, req_ready}, 32'd1);
    check("rs_mem_intact", mem[4], 32'h8899AABB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
